// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the single VGA adapter write port among three pixel
// plotters. Requesters stream pixels under req/ack. A round-robin grant lasts
// for one burst, which ends on `last`, on req withdrawal, or when MAX_BURST
// pixels have been consumed. All VGA-facing outputs are registered.
module plot_arbiter #(
  parameter int MAX_BURST = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] req,
  input  logic [2:0] last,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  input  logic [6:0] y2,
  input  logic [2:0] c0,
  input  logic [2:0] c1,
  input  logic [2:0] c2,
  output logic [2:0] gnt,
  output logic [2:0] ack,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // burst_cnt value at which the pixel being consumed is the last one allowed
  localparam logic [7:0] CAP_LAST = 8'(MAX_BURST - 1);

  state_t     state, state_next;
  logic [1:0] owner, owner_next;
  logic [1:0] rr_ptr, rr_ptr_next;
  logic [7:0] burst_cnt, burst_cnt_next;
  logic [2:0] gnt_next;
  logic [7:0] vga_x_next;
  logic [6:0] vga_y_next;
  logic [2:0] vga_colour_next;
  logic       vga_plot_next;

  // owner's view of the requester inputs
  logic       own_req;
  logic       own_last;
  logic [7:0] own_x;
  logic [6:0] own_y;
  logic [2:0] own_c;

  // round-robin candidate chosen while idle
  logic       pick_valid;
  logic [1:0] pick;
  logic [1:0] cand1, cand2, cand3;

  // Requester indices live in 0..2; index 3 never exists, so 2 wraps to 0.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic bit_of(input logic [2:0] vec, input logic [1:0] idx);
    case (idx)
      2'd0:    return vec[0];
      2'd1:    return vec[1];
      default: return vec[2];
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Acks are only meaningful in BUSY and are suppressed on a reset edge so a
  // requester never advances past a pixel that was not plotted.
  assign ack = (resetn && state == BUSY) ? (gnt & req) : 3'b000;

  // Multiplex the current owner's pixel and handshake bits.
  always_comb begin
    own_req  = bit_of(req, owner);
    own_last = bit_of(last, owner);
    case (owner)
      2'd0: begin
        own_x = x0;
        own_y = y0;
        own_c = c0;
      end
      2'd1: begin
        own_x = x1;
        own_y = y1;
        own_c = c1;
      end
      default: begin
        own_x = x2;
        own_y = y2;
        own_c = c2;
      end
    endcase
  end

  // Search rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 3) for the first active request.
  always_comb begin
    cand1      = wrap_inc(rr_ptr);
    cand2      = wrap_inc(cand1);
    cand3      = wrap_inc(cand2);
    pick_valid = 1'b1;
    pick       = cand1;
    if (bit_of(req, cand1)) begin
      pick = cand1;
    end else if (bit_of(req, cand2)) begin
      pick = cand2;
    end else if (bit_of(req, cand3)) begin
      pick = cand3;
    end else begin
      pick_valid = 1'b0;
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_next      = state;
    owner_next      = owner;
    rr_ptr_next     = rr_ptr;
    burst_cnt_next  = burst_cnt;
    gnt_next        = gnt;
    vga_x_next      = vga_x;
    vga_y_next      = vga_y;
    vga_colour_next = vga_colour;
    vga_plot_next   = 1'b0;

    case (state)
      IDLE: begin
        gnt_next = 3'b000;
        if (pick_valid) begin
          owner_next     = pick;
          rr_ptr_next    = pick;
          burst_cnt_next = 8'd0;
          gnt_next       = onehot(pick);
          state_next     = BUSY;
        end
      end

      BUSY: begin
        if (!own_req) begin
          // withdrawal wins over last: nothing is written this edge
          gnt_next   = 3'b000;
          state_next = IDLE;
        end else begin
          vga_x_next      = own_x;
          vga_y_next      = own_y;
          vga_colour_next = own_c;
          vga_plot_next   = 1'b1;
          burst_cnt_next  = burst_cnt + 8'd1;
          if (own_last || burst_cnt == CAP_LAST) begin
            gnt_next   = 3'b000;
            state_next = IDLE;
          end
        end
      end

      default: begin
        gnt_next   = 3'b000;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // computed from the previous cycle, independent of statement order.
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 2'd0;
      rr_ptr     <= 2'd2;
      burst_cnt  <= 8'd0;
      gnt        <= 3'b000;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      vga_plot   <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      rr_ptr     <= rr_ptr_next;
      burst_cnt  <= burst_cnt_next;
      gnt        <= gnt_next;
      vga_x      <= vga_x_next;
      vga_y      <= vga_y_next;
      vga_colour <= vga_colour_next;
      vga_plot   <= vga_plot_next;
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter. Two instances (burst cap 64 and 4)
// are driven by queue-based requester models; a cycle-level reference model
// of the grant rules predicts gnt/ack/vga outputs every cycle, and directed
// steps add explicit grant-order, plot-count and data checks.
module tb_plot_arbiter;

  localparam int NI   = 2;
  localparam int CAP0 = 64;
  localparam int CAP1 = 4;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       last;
  } pix_t;

  logic       clk = 1'b0;
  logic       resetn [NI];
  logic [2:0] req    [NI];
  logic [2:0] last   [NI];
  logic [7:0] xi     [NI][3];
  logic [6:0] yi     [NI][3];
  logic [2:0] ci     [NI][3];
  logic [2:0] gnt    [NI];
  logic [2:0] ack    [NI];
  logic [7:0] vx     [NI];
  logic [6:0] vy     [NI];
  logic [2:0] vc     [NI];
  logic       vp     [NI];

  always #5 clk = ~clk;

  plot_arbiter #(.MAX_BURST(CAP0)) dut0 (
    .clk(clk), .resetn(resetn[0]), .req(req[0]), .last(last[0]),
    .x0(xi[0][0]), .x1(xi[0][1]), .x2(xi[0][2]),
    .y0(yi[0][0]), .y1(yi[0][1]), .y2(yi[0][2]),
    .c0(ci[0][0]), .c1(ci[0][1]), .c2(ci[0][2]),
    .gnt(gnt[0]), .ack(ack[0]), .vga_x(vx[0]), .vga_y(vy[0]),
    .vga_colour(vc[0]), .vga_plot(vp[0])
  );

  plot_arbiter #(.MAX_BURST(CAP1)) dut1 (
    .clk(clk), .resetn(resetn[1]), .req(req[1]), .last(last[1]),
    .x0(xi[1][0]), .x1(xi[1][1]), .x2(xi[1][2]),
    .y0(yi[1][0]), .y1(yi[1][1]), .y2(yi[1][2]),
    .c0(ci[1][0]), .c1(ci[1][1]), .c2(ci[1][2]),
    .gnt(gnt[1]), .ack(ack[1]), .vga_x(vx[1]), .vga_y(vy[1]),
    .vga_colour(vc[1]), .vga_plot(vp[1])
  );

  // requester models: pending pixels per requester, plus a withdraw switch
  pix_t q   [NI][3][$];
  bit   off [NI][3];
  int   cap [NI];

  // reference model state
  bit         m_valid [NI];
  bit         m_busy  [NI];
  int         m_who   [NI];
  int         m_count [NI];
  int         m_prev  [NI];
  logic       m_plot  [NI];
  logic [7:0] m_x     [NI];
  logic [6:0] m_y     [NI];
  logic [2:0] m_c     [NI];

  // observation logs
  int   plots     [NI];
  int   run_len   [NI];
  int   max_run   [NI];
  pix_t plot_log  [NI][$];
  int   grant_log [NI][$];
  logic [2:0] prev_gnt [NI];

  // values seen just before each active edge
  logic       s_rst  [NI];
  logic [2:0] s_req  [NI];
  logic [2:0] s_last [NI];
  logic [2:0] s_ack  [NI];
  pix_t       s_pix  [NI][3];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic pix_t mk(input logic [7:0] x, input logic [6:0] y,
                              input logic [2:0] c, input logic l);
    pix_t p;
    p.x = x; p.y = y; p.c = c; p.last = l;
    return p;
  endfunction

  function automatic int gidx(input logic [2:0] g);
    case (g)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int got_grant(input int k, input int i);
    return (i < grant_log[k].size()) ? grant_log[k][i] : -1;
  endfunction

  // Present each requester's head pixel; idle requesters show junk data.
  task automatic drive(input int k);
    for (int i = 0; i < 3; i++) begin
      if (q[k][i].size() > 0) begin
        req[k][i]  = !off[k][i];
        xi[k][i]   = q[k][i][0].x;
        yi[k][i]   = q[k][i][0].y;
        ci[k][i]   = q[k][i][0].c;
        last[k][i] = q[k][i][0].last;
      end else begin
        req[k][i]  = 1'b0;
        xi[k][i]   = 8'($urandom);
        yi[k][i]   = 7'($urandom);
        ci[k][i]   = 3'($urandom);
        last[k][i] = 1'($urandom);
      end
    end
  endtask

  // Apply the arbitration rules to the inputs sampled at one edge.
  task automatic model_edge(input int k);
    int cand;
    if (s_rst[k] !== 1'b1) begin
      m_valid[k] = 1'b1;
      m_busy[k]  = 1'b0;
      m_prev[k]  = 2;
      m_count[k] = 0;
      m_plot[k]  = 1'b0;
      m_x[k] = '0; m_y[k] = '0; m_c[k] = '0;
    end else if (m_valid[k]) begin
      m_plot[k] = 1'b0;
      if (!m_busy[k]) begin
        for (int step_i = 1; step_i <= 3; step_i++) begin
          cand = (m_prev[k] + step_i) % 3;
          if (!m_busy[k] && s_req[k][cand]) begin
            m_busy[k]  = 1'b1;
            m_who[k]   = cand;
            m_prev[k]  = cand;
            m_count[k] = 0;
          end
        end
      end else if (!s_req[k][m_who[k]]) begin
        m_busy[k] = 1'b0;
      end else begin
        m_x[k]     = s_pix[k][m_who[k]].x;
        m_y[k]     = s_pix[k][m_who[k]].y;
        m_c[k]     = s_pix[k][m_who[k]].c;
        m_plot[k]  = 1'b1;
        m_count[k] = m_count[k] + 1;
        if (s_last[k][m_who[k]] || m_count[k] == cap[k]) m_busy[k] = 1'b0;
      end
    end
  endtask

  // One clock: compare on the falling edge, then update models after rising.
  task automatic step();
    logic [2:0] exp_gnt;
    logic [2:0] exp_ack;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      exp_gnt = m_busy[k] ? (3'b001 << m_who[k]) : 3'b000;
      exp_ack = (resetn[k] && m_busy[k]) ? (exp_gnt & req[k]) : 3'b000;
      if (m_valid[k] || !resetn[k])
        check($sformatf("ack%0d", k), 32'(ack[k]), 32'(exp_ack));
      if (m_valid[k]) begin
        check($sformatf("gnt%0d", k), 32'(gnt[k]), 32'(exp_gnt));
        check($sformatf("plot%0d", k), 32'(vp[k]), 32'(m_plot[k]));
        check($sformatf("pix%0d", k), 32'({vx[k], vy[k], vc[k]}),
              32'({m_x[k], m_y[k], m_c[k]}));
      end
      if (vp[k] === 1'b1) begin
        plots[k]++;
        plot_log[k].push_back(mk(vx[k], vy[k], vc[k], 1'b0));
        run_len[k]++;
        if (run_len[k] > max_run[k]) max_run[k] = run_len[k];
      end else begin
        run_len[k] = 0;
      end
      if (prev_gnt[k] === 3'b000 && gnt[k] !== 3'b000)
        grant_log[k].push_back(gidx(gnt[k]));
      prev_gnt[k] = gnt[k];
      s_rst[k]  = resetn[k];
      s_req[k]  = req[k];
      s_last[k] = last[k];
      s_ack[k]  = ack[k];
      for (int i = 0; i < 3; i++) s_pix[k][i] = mk(xi[k][i], yi[k][i], ci[k][i], last[k][i]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      model_edge(k);
      for (int i = 0; i < 3; i++)
        if (s_ack[k][i] === 1'b1 && q[k][i].size() > 0) void'(q[k][i].pop_front());
      drive(k);
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < NI; k++) resetn[k] = 1'b0;
    repeat (n) step();
    for (int k = 0; k < NI; k++) begin
      resetn[k] = 1'b1;
      drive(k);
    end
  endtask

  task automatic clear_logs(input int k);
    plots[k] = 0; run_len[k] = 0; max_run[k] = 0;
    plot_log[k].delete();
    grant_log[k].delete();
  endtask

  function automatic bit pending(input int k);
    return m_busy[k] || q[k][0].size() > 0 || q[k][1].size() > 0 || q[k][2].size() > 0;
  endfunction

  // Bounded wait for instance k to drain all requesters and return to idle.
  task automatic run_until_idle(input int k, input int max_cycles, input string tag);
    int n;
    n = 0;
    while (pending(k) && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < max_cycles), 32'd1);
    repeat (2) step();
  endtask

  initial begin
    pix_t exp_q[$];
    int   exp_b[4];
    int   r;
    int   n;

    cap[0] = CAP0;
    cap[1] = CAP1;
    for (int k = 0; k < NI; k++) begin
      resetn[k] = 1'b0;
      prev_gnt[k] = 3'b000;
      for (int i = 0; i < 3; i++) off[k][i] = 1'b0;
      drive(k);
    end

    // ---- reset and single pixel ----
    do_reset(2);
    check("rst_gnt", 32'(gnt[0]), 32'd0);
    check("rst_plot", 32'(vp[0]), 32'd0);
    check("rst_pix", 32'({vx[0], vy[0], vc[0]}), 32'd0);
    clear_logs(0);
    q[0][0].push_back(mk(8'd118, 7'd4, 3'd1, 1'b1));
    drive(0);
    step();
    check("single_gnt", 32'(gnt[0]), 32'b001);
    check("single_ack", 32'(ack[0]), 32'b001);
    check("single_noplot", 32'(vp[0]), 32'd0);
    step();
    check("single_plot", 32'(vp[0]), 32'd1);
    check("single_pix", 32'({vx[0], vy[0], vc[0]}), 32'({8'd118, 7'd4, 3'd1}));
    check("single_release", 32'(gnt[0]), 32'b000);
    step();
    check("single_plot_once", 32'(vp[0]), 32'd0);
    run_until_idle(0, 20, "single");
    check("single_count", 32'(plots[0]), 32'd1);

    // ---- round robin with all three requesting continuously ----
    do_reset(1);
    clear_logs(0);
    for (int i = 0; i < 3; i++)
      repeat (2) q[0][i].push_back(mk(8'(40 + i), 7'(i), 3'(i + 2), 1'b1));
    drive(0);
    run_until_idle(0, 60, "rr");
    check("rr_ngrants", 32'(grant_log[0].size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("rr_order%0d", i), 32'(got_grant(0, i)), 32'(i % 3));
    check("rr_count", 32'(plots[0]), 32'd6);

    // ---- burst cap (MAX_BURST=4), requester 0 alone ----
    do_reset(1);
    clear_logs(1);
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(mk(8'($urandom), 7'($urandom), 3'($urandom), 1'b0));
      q[1][0].push_back(exp_q[i]);
    end
    drive(1);
    run_until_idle(1, 100, "cap");
    check("cap_count", 32'(plots[1]), 32'd10);
    check("cap_maxrun", 32'(max_run[1]), 32'd4);
    check("cap_ngrants", 32'(grant_log[1].size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("cap_owner%0d", i), 32'(got_grant(1, i)), 32'd0);
    for (int i = 0; i < 10; i++)
      check($sformatf("cap_data%0d", i),
            32'((i < plot_log[1].size()) ? {plot_log[1][i].x, plot_log[1][i].y, plot_log[1][i].c} : 18'h3ffff),
            32'({exp_q[i].x, exp_q[i].y, exp_q[i].c}));

    // ---- burst cap with a second requester waiting ----
    do_reset(1);
    clear_logs(1);
    repeat (10) q[1][0].push_back(mk(8'($urandom), 7'($urandom), 3'($urandom), 1'b0));
    repeat (4)  q[1][1].push_back(mk(8'($urandom), 7'($urandom), 3'($urandom), 1'b0));
    drive(1);
    run_until_idle(1, 100, "cap2");
    exp_b = '{0, 1, 0, 0};
    check("cap2_ngrants", 32'(grant_log[1].size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("cap2_owner%0d", i), 32'(got_grant(1, i)), 32'(exp_b[i]));
    check("cap2_count", 32'(plots[1]), 32'd14);

    // ---- withdrawal after three pixels ----
    do_reset(1);
    clear_logs(0);
    repeat (3) q[0][2].push_back(mk(8'($urandom), 7'($urandom), 3'($urandom), 1'b0));
    drive(0);
    run_until_idle(0, 30, "wd");
    check("wd_count", 32'(plots[0]), 32'd3);
    check("wd_owner", 32'(got_grant(0, 0)), 32'd2);
    check("wd_ngrants", 32'(grant_log[0].size()), 32'd1);
    check("wd_gnt_clear", 32'(gnt[0]), 32'd0);

    // ---- reset in the middle of a burst ----
    do_reset(1);
    clear_logs(0);
    repeat (5) q[0][0].push_back(mk(8'($urandom_range(1, 255)), 7'($urandom_range(1, 127)), 3'd5, 1'b0));
    drive(0);
    n = 0;
    while (plots[0] < 2 && n < 20) begin
      step();
      n++;
    end
    check("mid_timeout", 32'(n < 20), 32'd1);
    check("mid_pre_ack", 32'(ack[0]), 32'b001);
    r = plots[0];
    resetn[0] = 1'b0;
    step();
    resetn[0] = 1'b1;
    check("mid_gnt", 32'(gnt[0]), 32'd0);
    check("mid_pix", 32'({vx[0], vy[0], vc[0]}), 32'd0);
    check("mid_noplot", 32'(vp[0]), 32'd0);
    clear_logs(0);
    q[0][1].push_back(mk(8'd7, 7'd7, 3'd7, 1'b1));
    q[0][2].push_back(mk(8'd9, 7'd9, 3'd3, 1'b1));
    drive(0);
    run_until_idle(0, 40, "mid");
    check("mid_first", 32'(got_grant(0, 0)), 32'd0);
    check("mid_second", 32'(got_grant(0, 1)), 32'd1);
    check("mid_third", 32'(got_grant(0, 2)), 32'd2);

    // ---- 33-pixel restore stream on requester 1 ----
    do_reset(1);
    clear_logs(0);
    exp_q.delete();
    for (int j = 0; j < 17; j++) exp_q.push_back(mk(8'd118, 7'(10 + 3 * j), 3'd1, 1'b0));
    for (int j = 0; j < 16; j++) exp_q.push_back(mk(8'd123, 7'(10 + 3 * j), 3'd1, j == 15));
    for (int j = 0; j < 33; j++) q[0][1].push_back(exp_q[j]);
    drive(0);
    run_until_idle(0, 100, "stream");
    check("stream_count", 32'(plots[0]), 32'd33);
    check("stream_run", 32'(max_run[0]), 32'd33);
    check("stream_ngrants", 32'(grant_log[0].size()), 32'd1);
    for (int j = 0; j < 33; j++)
      check($sformatf("stream_pix%0d", j),
            32'((j < plot_log[0].size()) ? {plot_log[0][j].x, plot_log[0][j].y, plot_log[0][j].c} : 18'h3ffff),
            32'({exp_q[j].x, exp_q[j].y, exp_q[j].c}));

    // ---- randomized traffic, withdrawals and resets on both instances ----
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < NI; k++) begin
        r = $urandom_range(0, 2);
        if ($urandom_range(0, 3) == 0 && q[k][r].size() < 6)
          repeat ($urandom_range(1, 3))
            q[k][r].push_back(mk(8'($urandom), 7'($urandom), 3'($urandom), $urandom_range(0, 4) == 0));
        for (int i = 0; i < 3; i++) off[k][i] = ($urandom_range(0, 9) == 0);
        resetn[k] = ($urandom_range(0, 59) != 0);
        drive(k);
      end
      step();
    end
    for (int k = 0; k < NI; k++) begin
      resetn[k] = 1'b1;
      for (int i = 0; i < 3; i++) off[k][i] = 1'b0;
      drive(k);
    end
    run_until_idle(0, 300, "rand0");
    run_until_idle(1, 300, "rand1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
